// File: rtl/mac_norm_stage.sv
// rtl/mac_norm_stage.sv - two-stage leading-zero normalizer with valid/ready handshake
module mac_norm_stage #(
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [EW-1:0] in_exp,
    input  logic [31:0]   in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [31:0]   out_mant,
    output logic [5:0]    out_lzc,
    output logic          out_zero,
    output logic          out_uf
);

    // stage 1 registers
    logic          v1;
    logic          s1_sign;
    logic [EW-1:0] s1_exp;
    logic [31:0]   s1_mant;
    logic [4:0]    s1_lzc;
    logic          s1_zero;

    // stage 2 valid; the out_* registers are the stage 2 data
    logic v2;
    logic adv2;

    // leading-zero detect on the incoming beat
    logic [7:0] nib_zero;
    logic [1:0] nib_pos [8];
    logic [2:0] grp;
    logic [1:0] pos;

    // stage 2 shift computation
    logic       uf_raw;
    logic [4:0] sh;

    assign adv2      = ~v2 | out_ready;
    assign in_ready  = ~v1 | adv2;
    assign out_valid = v2;

    // nibble encoders (nibble 0 is the most significant), then first non-zero nibble wins
    always_comb begin
        nib_zero = '0;
        for (int k = 0; k < 8; k++) begin
            nib_zero[k] = (in_mant[31-4*k -: 4] == 4'h0);
            if (in_mant[31-4*k])
                nib_pos[k] = 2'd0;
            else if (in_mant[30-4*k])
                nib_pos[k] = 2'd1;
            else if (in_mant[29-4*k])
                nib_pos[k] = 2'd2;
            else
                nib_pos[k] = 2'd3;
        end
        grp = 3'd7;
        for (int k = 7; k >= 0; k--) begin
            if (!nib_zero[k])
                grp = k[2:0];
        end
        pos = nib_pos[grp];
    end

    // shift is clamped to the exponent so the exponent never goes below zero
    always_comb begin
        uf_raw = (s1_exp < EW'(s1_lzc));
        sh     = uf_raw ? s1_exp[4:0] : s1_lzc;
    end

    // stage 1: capture the beat and its leading-zero count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_lzc  <= '0;
            s1_zero <= 1'b0;
        end else if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_lzc  <= {grp, pos};
                s1_zero <= &nib_zero;
            end
        end
    end

    // stage 2: shift and adjust; data only moves with a valid beat so stalls hold outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2       <= 1'b0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
            out_lzc  <= '0;
            out_zero <= 1'b0;
            out_uf   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_sign <= s1_sign;
                if (s1_zero) begin
                    out_exp  <= '0;
                    out_mant <= '0;
                    out_lzc  <= 6'd32;
                    out_zero <= 1'b1;
                    out_uf   <= 1'b0;
                end else begin
                    out_exp  <= s1_exp - EW'(sh);
                    out_mant <= s1_mant << sh;
                    out_lzc  <= {1'b0, sh};
                    out_zero <= 1'b0;
                    out_uf   <= uf_raw;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_norm_stage.sv
// tb/tb_mac_norm_stage.sv - self-checking bench for mac_norm_stage
module tb_mac_norm_stage;

    localparam int EW = 8;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [31:0]   mant;
        logic [5:0]    lzc;
        logic          zero;
        logic          uf;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic [31:0]   in_mant = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [31:0]   out_mant;
    logic [5:0]    out_lzc;
    logic          out_zero;
    logic          out_uf;

    int tests = 0;
    int fails = 0;

    res_t cur;
    assign cur = '{out_sign, out_exp, out_mant, out_lzc, out_zero, out_uf};

    mac_norm_stage #(.EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_lzc(out_lzc), .out_zero(out_zero), .out_uf(out_uf)
    );

    always #5 clk = ~clk;

    // reference: count leading zeros bit by bit, clamp to the exponent
    function automatic res_t ref_norm(input logic s, input logic [EW-1:0] e, input logic [31:0] m);
        res_t r;
        int lz;
        int sh;
        r.sign = s;
        if (m == 32'd0) begin
            r.exp = '0; r.mant = '0; r.lzc = 6'd32; r.zero = 1'b1; r.uf = 1'b0;
        end else begin
            lz = 0;
            while (m[31-lz] == 1'b0) lz++;
            sh = (lz < int'(e)) ? lz : int'(e);
            r.mant = m << sh;
            r.exp  = EW'(int'(e) - sh);
            r.lzc  = 6'(sh);
            r.zero = 1'b0;
            r.uf   = (lz > int'(e));
        end
        return r;
    endfunction

    task automatic send_one(input logic s, input logic [EW-1:0] e, input logic [31:0] m,
                            output logic early, output logic late, output res_t r);
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        early = out_valid;
        @(negedge clk);
        late = out_valid;
        r = cur;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        tests++;
        if (cur !== res_t'(0)) begin fails++; $display("FAIL reset_data got=%h want=0", cur); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic          vs [4];
        logic [EW-1:0] ve [4];
        logic [31:0]   vm [4];
        res_t          vx [4];
        logic early, late;
        res_t r;
        vs[0] = 1'b1; ve[0] = 8'd100; vm[0] = 32'h0000_1000; vx[0] = '{1'b1, 8'd81, 32'h8000_0000, 6'd19, 1'b0, 1'b0};
        vs[1] = 1'b0; ve[1] = 8'd0;   vm[1] = 32'h8000_0001; vx[1] = '{1'b0, 8'd0,  32'h8000_0001, 6'd0,  1'b0, 1'b0};
        vs[2] = 1'b1; ve[2] = 8'd77;  vm[2] = 32'h0000_0000; vx[2] = '{1'b1, 8'd0,  32'h0000_0000, 6'd32, 1'b1, 1'b0};
        vs[3] = 1'b0; ve[3] = 8'd5;   vm[3] = 32'h0000_0001; vx[3] = '{1'b0, 8'd0,  32'h0000_0020, 6'd5,  1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_one(vs[i], ve[i], vm[i], early, late, r);
            tests++;
            if (early !== 1'b0) begin fails++; $display("FAIL dir%0d_early_valid got=%b want=0", i, early); end
            tests++;
            if (late !== 1'b1) begin fails++; $display("FAIL dir%0d_latency got=%b want=1", i, late); end
            tests++;
            if (r !== vx[i]) begin fails++; $display("FAIL dir%0d_result got=%h want=%h", i, r, vx[i]); end
        end
    endtask

    task automatic test_sweep();
        logic early, late;
        res_t r, x;
        for (int p = 0; p < 32; p++) begin
            send_one(p[0], 8'd200, 32'd1 << p, early, late, r);
            x.sign = p[0];
            x.lzc  = 6'(31 - p);
            x.exp  = 8'(200 - (31 - p));
            x.mant = 32'h8000_0000;
            x.zero = 1'b0;
            x.uf   = 1'b0;
            tests++;
            if (late !== 1'b1 || r !== x) begin
                fails++; $display("FAIL sweep_bit%0d got=%h valid=%b want=%h", p, r, late, x);
            end
        end
    endtask

    // mode 0: random valid/ready; mode 1: full rate; mode 2: ready low for cycles 3..6
    task automatic test_stream(input int mode, input int n);
        res_t q[$];
        res_t held, x;
        logic stalled = 1'b0;
        logic saw_block = 1'b0;
        logic exp_ready;
        int sent = 0;
        int popped = 0;
        int cyc = 0;
        while ((sent < n || q.size() > 0) && cyc < 2000) begin
            @(negedge clk);
            if (stalled) begin
                tests++;
                if (out_valid !== 1'b1 || cur !== held) begin
                    fails++; $display("FAIL m%0d_hold cyc=%0d got=%h v=%b want=%h", mode, cyc, cur, out_valid, held);
                end
            end
            in_valid = (sent < n) ? ((mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
            in_sign  = 1'($urandom_range(0, 1));
            in_exp   = ($urandom_range(0, 1) == 0) ? EW'($urandom_range(0, 40)) : EW'($urandom_range(0, 255));
            in_mant  = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            case (mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b1;
                default: out_ready = !(cyc >= 3 && cyc <= 6);
            endcase
            #1;
            exp_ready = (q.size() < 2) || out_ready;
            tests++;
            if (in_ready !== exp_ready) begin
                fails++; $display("FAIL m%0d_in_ready cyc=%0d got=%b want=%b", mode, cyc, in_ready, exp_ready);
            end
            if (!in_ready) saw_block = 1'b1;
            if (out_valid === 1'b1 && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL m%0d_spurious cyc=%0d got=%h want=none", mode, cyc, cur);
                end else begin
                    x = q.pop_front();
                    popped++;
                    if (cur !== x) begin
                        fails++; $display("FAIL m%0d_data cyc=%0d got=%h want=%h", mode, cyc, cur, x);
                    end
                end
            end
            stalled = out_valid & ~out_ready;
            held = cur;
            if (in_valid && in_ready) begin
                q.push_back(ref_norm(in_sign, in_exp, in_mant));
                sent++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        tests++;
        if (cyc >= 2000 || popped != n) begin
            fails++; $display("FAIL m%0d_count got=%0d want=%0d cyc=%0d", mode, popped, n, cyc);
        end
        if (mode == 1) begin
            tests++;
            if (cyc != n + 2) begin fails++; $display("FAIL m1_throughput got=%0d want=%0d", cyc, n + 2); end
        end
        if (mode == 2) begin
            tests++;
            if (saw_block !== 1'b1) begin fails++; $display("FAIL m2_backpressure got=%b want=1", saw_block); end
        end
    endtask

    task automatic test_reset_midstream();
        logic early, late;
        res_t r, x;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_sign = 1'b1; in_exp = 8'd50; in_mant = 32'h0001_2345;
        @(negedge clk);
        in_mant = 32'h00F0_0000;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL mid_full got=v%b r%b want=v1 r0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || cur !== res_t'(0)) begin
            fails++; $display("FAIL mid_reset got=v%b %h want=v0 0", out_valid, cur);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b want=1", in_ready); end
        send_one(1'b0, 8'd9, 32'h0000_0300, early, late, r);
        x = '{1'b0, 8'd0, 32'h0000_0300 << 9, 6'd9, 1'b0, 1'b1};
        tests++;
        if (early !== 1'b0 || late !== 1'b1 || r !== x) begin
            fails++; $display("FAIL mid_after got=%h e%b l%b want=%h", r, early, late, x);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d got=%b want=0", i, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sweep();
        test_stream(0, 60);
        test_stream(1, 20);
        test_stream(2, 10);
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
